// File: rtl/pulse_level_conv.sv
// Multi-channel pulse/level converter: each channel runs as toggle, stretch, edge
// detector or sticky flag, selected per channel at run time.
module pulse_level_conv #(
   parameter int CH    = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH-1:0]       en,
   input  logic [CH-1:0]       clr,
   input  logic [2*CH-1:0]     mode,
   input  logic [CNT_W-1:0]    stretch_len,
   input  logic [CH-1:0]       d,
   output logic [CH-1:0]       lvl,
   output logic [CH-1:0]       busy
);

   localparam logic [1:0] MODE_TOGGLE  = 2'b00;
   localparam logic [1:0] MODE_STRETCH = 2'b01;
   localparam logic [1:0] MODE_EDGE    = 2'b10;
   localparam logic [1:0] MODE_STICKY  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [1:0]       mode_i;
      logic [1:0]       mode_q;
      logic [CNT_W-1:0] cnt;
      logic             lvl_q;
      logic             d_q;

      assign mode_i = mode[2*gi +: 2];

      // NOTE: every register here uses non-blocking assignment so all channels
      // and all state bits update from the same pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lvl_q  <= 1'b0;
            cnt    <= '0;
            d_q    <= 1'b0;
            mode_q <= MODE_TOGGLE;
         end else begin
            d_q    <= d[gi];
            mode_q <= mode_i;
            if (clr[gi] || (mode_i != mode_q)) begin
               // A mode switch behaves like a clear so no state leaks across modes.
               lvl_q <= 1'b0;
               cnt   <= '0;
            end else if (!en[gi]) begin
               if (mode_i == MODE_EDGE) lvl_q <= 1'b0;
            end else begin
               case (mode_i)
                  MODE_TOGGLE:  lvl_q <= lvl_q ^ d[gi];
                  MODE_STRETCH: begin
                     // lvl_q tracks the next counter value so lvl and busy agree.
                     if (d[gi]) begin
                        cnt   <= stretch_len;
                        lvl_q <= |stretch_len;
                     end else if (cnt != '0) begin
                        cnt   <= cnt - CNT_ONE;
                        lvl_q <= (cnt != CNT_ONE);
                     end
                  end
                  MODE_EDGE:    lvl_q <= d[gi] ^ d_q;
                  MODE_STICKY:  lvl_q <= lvl_q | d[gi];
               endcase
            end
         end
      end

      assign lvl[gi]  = lvl_q;
      assign busy[gi] = |cnt;
   end

endmodule

// File: tb/tb_pulse_level_conv.sv
// Directed bench for pulse_level_conv: stimulus pushes hand-computed lvl/busy
// into a scoreboard queue, a negedge monitor pops and compares.
module tb_pulse_level_conv;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] en;
   logic [3:0] clr;
   logic [7:0] mode;
   logic [7:0] stretch_len;
   logic [3:0] d;
   logic [3:0] lvl;
   logic [3:0] busy;

   typedef struct {
      logic [3:0] l;
      logic [3:0] b;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   pulse_level_conv #(.CH(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .clr         (clr),
      .mode        (mode),
      .stretch_len (stretch_len),
      .d           (d),
      .lvl         (lvl),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         if (lvl !== e.l || busy !== e.b) begin
            n_miss++;
            $display("FAIL %s (vector %0d): got lvl=%b busy=%b, expected lvl=%b busy=%b",
                     e.tag, n_vec, lvl, busy, e.l, e.b);
         end
      end
   end

   task automatic push_exp(input logic [3:0] l, input logic [3:0] b, input string tag);
      exp_t e;
      e.l = l;
      e.b = b;
      e.tag = tag;
      q.push_back(e);
   endtask

   // Drive d for one rising edge; expectation describes outputs after that edge.
   task automatic apply(input logic [3:0] d_v, input logic [3:0] exp_l,
                        input logic [3:0] exp_b, input string tag);
      d = d_v;
      @(posedge clk);
      push_exp(exp_l, exp_b, tag);
      @(negedge clk);
      #1;
   endtask

   task automatic clear_all(input logic [7:0] mode_v);
      mode = mode_v;
      clr  = 4'hF;
      apply(4'h0, 4'h0, 4'h0, "clear_all");
      clr  = 4'h0;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 4'hF;
      clr = 4'h0;
      mode = 8'h00;
      stretch_len = 8'd5;
      d = 4'h0;

      // Reset holds everything low even with activity on d.
      apply(4'hF, 4'h0, 4'h0, "reset_hold");
      apply(4'hF, 4'h0, 4'h0, "reset_hold");
      d = 4'h0;
      rst_n = 1'b1;

      // Toggle: d[0] pulses at edges 2, 5, 9.
      apply(4'h0, 4'h0, 4'h0, "toggle");
      apply(4'h1, 4'h1, 4'h0, "toggle");
      apply(4'h0, 4'h1, 4'h0, "toggle");
      apply(4'h0, 4'h1, 4'h0, "toggle");
      apply(4'h1, 4'h0, 4'h0, "toggle");
      apply(4'h0, 4'h0, 4'h0, "toggle");
      apply(4'h0, 4'h0, 4'h0, "toggle");
      apply(4'h0, 4'h0, 4'h0, "toggle");
      apply(4'h1, 4'h1, 4'h0, "toggle");
      apply(4'h0, 4'h1, 4'h0, "toggle");

      // Stretch on ch1, len=5, retrigger at edge 6, len change mid-run ignored.
      stretch_len = 8'd5;
      clear_all(8'h04);
      apply(4'h0, 4'h0, 4'h0, "stretch");
      apply(4'h0, 4'h0, 4'h0, "stretch");
      apply(4'h2, 4'h2, 4'h2, "stretch_trig");
      apply(4'h0, 4'h2, 4'h2, "stretch");
      apply(4'h0, 4'h2, 4'h2, "stretch");
      apply(4'h2, 4'h2, 4'h2, "stretch_retrig");
      stretch_len = 8'd2;
      apply(4'h0, 4'h2, 4'h2, "stretch_len_chg");
      apply(4'h0, 4'h2, 4'h2, "stretch");
      apply(4'h0, 4'h2, 4'h2, "stretch");
      apply(4'h0, 4'h2, 4'h2, "stretch_last");
      apply(4'h0, 4'h0, 4'h0, "stretch_end");
      // len=0 cancels a running stretch and produces nothing.
      stretch_len = 8'd5;
      apply(4'h2, 4'h2, 4'h2, "stretch_trig");
      apply(4'h0, 4'h2, 4'h2, "stretch");
      stretch_len = 8'd0;
      apply(4'h2, 4'h0, 4'h0, "stretch_len0_cancel");
      apply(4'h2, 4'h0, 4'h0, "stretch_len0");
      apply(4'h0, 4'h0, 4'h0, "stretch_len0");
      stretch_len = 8'd1;
      apply(4'h2, 4'h2, 4'h2, "stretch_len1");
      apply(4'h0, 4'h0, 4'h0, "stretch_len1_end");

      // Edge on ch2: rise at edge 4, fall at edge 10, then a transition while disabled.
      clear_all(8'h20);
      apply(4'h0, 4'h0, 4'h0, "edge");
      apply(4'h0, 4'h0, 4'h0, "edge");
      apply(4'h0, 4'h0, 4'h0, "edge");
      apply(4'h4, 4'h4, 4'h0, "edge_rise");
      apply(4'h4, 4'h0, 4'h0, "edge");
      apply(4'h4, 4'h0, 4'h0, "edge");
      apply(4'h4, 4'h0, 4'h0, "edge");
      apply(4'h4, 4'h0, 4'h0, "edge");
      apply(4'h4, 4'h0, 4'h0, "edge");
      apply(4'h0, 4'h4, 4'h0, "edge_fall");
      apply(4'h0, 4'h0, 4'h0, "edge");
      en = 4'hB;
      apply(4'h0, 4'h0, 4'h0, "edge_dis");
      apply(4'h4, 4'h0, 4'h0, "edge_dis_trans");
      en = 4'hF;
      apply(4'h4, 4'h0, 4'h0, "edge_no_late");
      apply(4'h4, 4'h0, 4'h0, "edge");
      apply(4'h0, 4'h4, 4'h0, "edge_fall2");
      apply(4'h0, 4'h0, 4'h0, "edge");

      // Sticky on ch3 with clear winning over d.
      clear_all(8'hC0);
      apply(4'h0, 4'h0, 4'h0, "sticky");
      apply(4'h8, 4'h8, 4'h0, "sticky_set");
      apply(4'h0, 4'h8, 4'h0, "sticky");
      apply(4'h8, 4'h8, 4'h0, "sticky");
      apply(4'h0, 4'h8, 4'h0, "sticky");
      apply(4'h0, 4'h8, 4'h0, "sticky");
      clr = 4'h8;
      apply(4'h8, 4'h0, 4'h0, "sticky_clr_wins");
      clr = 4'h0;
      apply(4'h0, 4'h0, 4'h0, "sticky");
      apply(4'h8, 4'h8, 4'h0, "sticky_reset");
      en = 4'h7;
      apply(4'h0, 4'h8, 4'h0, "sticky_dis_hold");
      en = 4'hF;

      // All four modes at once, fed the same pulse.
      stretch_len = 8'd3;
      clear_all(8'hE4);
      apply(4'hF, 4'hF, 4'h2, "mixed");
      apply(4'h0, 4'hF, 4'h2, "mixed");
      apply(4'h0, 4'hB, 4'h2, "mixed");
      apply(4'h0, 4'h9, 4'h0, "mixed");

      // Mode change on ch0 mid-stretch discards the count and the pulse.
      stretch_len = 8'd5;
      clear_all(8'h01);
      apply(4'h1, 4'h1, 4'h1, "modechg_trig");
      apply(4'h0, 4'h1, 4'h1, "modechg");
      apply(4'h0, 4'h1, 4'h1, "modechg_cnt3");
      mode = 8'h00;
      apply(4'h1, 4'h0, 4'h0, "modechg_switch");
      apply(4'h0, 4'h0, 4'h0, "modechg");
      apply(4'h1, 4'h1, 4'h0, "modechg_toggle");
      apply(4'h0, 4'h1, 4'h0, "modechg_toggle");

      // Async reset while ch1 is stretching: outputs drop before the next edge.
      clear_all(8'h04);
      apply(4'h2, 4'h2, 4'h2, "arst_trig");
      apply(4'h0, 4'h2, 4'h2, "arst_busy");
      d = 4'h0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      push_exp(4'h0, 4'h0, "arst_immediate");
      @(negedge clk);
      #1;
      apply(4'h2, 4'h0, 4'h0, "arst_held");
      rst_n = 1'b1;
      apply(4'h2, 4'h0, 4'h0, "arst_release_modechg");
      apply(4'h0, 4'h0, 4'h0, "arst_idle");
      apply(4'h0, 4'h0, 4'h0, "arst_idle");
      apply(4'h2, 4'h2, 4'h2, "arst_retrig");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_miss++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
